// File: rtl/c64_debug_host_if.sv
// c64_debug_host_if
// Groups the command/response handshake and the UART byte-level links of the
// C64 debug host into one bundle.
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data : command request channel
//   rsp_valid/rsp_data/rsp_error                 : command completion channel
//   uart_tx_byte_valid/uart_tx_byte/uart_tx_busy : byte stream to the transmitter
//   uart_rx_byte_valid/uart_rx_byte              : byte stream from the receiver
// Modport slave is the debug host's view; modport master is the view of the
// agent that issues commands and models the UART.
interface c64_debug_host_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_error;
    logic        uart_tx_byte_valid;
    logic [7:0]  uart_tx_byte;
    logic        uart_tx_busy;
    logic        uart_rx_byte_valid;
    logic [7:0]  uart_rx_byte;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data,
        input  uart_tx_busy, uart_rx_byte_valid, uart_rx_byte,
        output cmd_ready, rsp_valid, rsp_data, rsp_error,
        output uart_tx_byte_valid, uart_tx_byte
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data,
        output uart_tx_busy, uart_rx_byte_valid, uart_rx_byte,
        input  cmd_ready, rsp_valid, rsp_data, rsp_error,
        input  uart_tx_byte_valid, uart_tx_byte
    );
endinterface

// File: rtl/c64_debug_host.sv
// c64_debug_host
// Turns read / write / ps2 commands into a UART byte sequence for a C64
// debug target and reports completion.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-low
//   bus   : c64_debug_host_if.slave (command, response and UART byte links)
// Read sends 0x01,AH,AL and waits for one reply byte; write sends
// 0x02,AH,AL,DATA and waits for an ack byte (0x06 = ok); ps2 sends
// 0x03,DATA,0x00 and completes without waiting. The reply wait is bounded by
// TIMEOUT_CYCLES. Every output is registered.
module c64_debug_host #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    c64_debug_host_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_OP   = 3'd1,
        SEND_AH   = 3'd2,
        SEND_AL   = 3'd3,
        SEND_DATA = 3'd4,
        WAIT_RSP  = 3'd5
    } state_t;

    localparam logic [1:0]  OP_ILLEGAL    = 2'd0;
    localparam logic [1:0]  OP_WRITE      = 2'd2;
    localparam logic [1:0]  OP_PS2        = 2'd3;
    localparam logic [7:0]  ACK_BYTE      = 8'h06;
    localparam logic [23:0] TIMEOUT_LIMIT = 24'(TIMEOUT_CYCLES);

    state_t      state_r;
    logic [1:0]  op_r;
    logic [15:0] addr_r;
    logic [7:0]  data_r;
    logic [23:0] wait_cnt_r;
    logic        cmd_ready_r;
    logic        rsp_valid_r;
    logic [7:0]  rsp_data_r;
    logic        rsp_error_r;
    logic        tx_valid_r;
    logic [7:0]  tx_byte_r;

    logic [7:0]  tx_next_byte_s;
    state_t      send_next_s;
    logic        tx_issue_s;

    // Completion status of a reply byte: only a write checks for the ack byte.
    function automatic logic status_for(input logic [1:0] op, input logic [7:0] rx);
        logic err;
        err = 1'b0;
        if (op == OP_WRITE) begin
            err = (rx != ACK_BYTE);
        end else begin
            err = 1'b0;
        end
        return err;
    endfunction

    // Byte to send from the current send state and the state that follows it.
    // A ps2 command reuses the AH/AL slots for its data byte and trailing 0x00.
    always_comb begin
        tx_next_byte_s = 8'h00;
        send_next_s    = IDLE;
        case (state_r)
            SEND_OP: begin
                tx_next_byte_s = {6'b000000, op_r};
                send_next_s    = SEND_AH;
            end
            SEND_AH: begin
                tx_next_byte_s = (op_r == OP_PS2) ? data_r : addr_r[15:8];
                send_next_s    = SEND_AL;
            end
            SEND_AL: begin
                tx_next_byte_s = (op_r == OP_PS2) ? 8'h00 : addr_r[7:0];
                send_next_s    = (op_r == OP_PS2)   ? IDLE :
                                 (op_r == OP_WRITE) ? SEND_DATA : WAIT_RSP;
            end
            SEND_DATA: begin
                tx_next_byte_s = data_r;
                send_next_s    = WAIT_RSP;
            end
            default: begin
                tx_next_byte_s = 8'h00;
                send_next_s    = IDLE;
            end
        endcase
    end

    // A byte may be issued when the transmitter is idle and the last cycle
    // carried no pulse; tx_valid_r doubles as the one-cycle gap flag.
    assign tx_issue_s = !bus.uart_tx_busy && !tx_valid_r;

    // Control FSM with registered handshake, response and UART outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            op_r        <= 2'd0;
            addr_r      <= 16'h0000;
            data_r      <= 8'h00;
            wait_cnt_r  <= 24'd0;
            cmd_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 8'h00;
            rsp_error_r <= 1'b0;
            tx_valid_r  <= 1'b0;
            tx_byte_r   <= 8'h00;
        end else begin
            rsp_valid_r <= 1'b0;
            tx_valid_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (tx_valid_r) begin
                        // Only a ps2 command returns here with a pulse in
                        // flight: complete it one cycle after its last byte.
                        rsp_valid_r <= 1'b1;
                        rsp_data_r  <= 8'h00;
                        rsp_error_r <= 1'b0;
                        cmd_ready_r <= 1'b0;
                    end else if (bus.cmd_valid && cmd_ready_r) begin
                        op_r        <= bus.cmd_op;
                        addr_r      <= bus.cmd_addr;
                        data_r      <= bus.cmd_data;
                        cmd_ready_r <= 1'b0;
                        if (bus.cmd_op == OP_ILLEGAL) begin
                            rsp_valid_r <= 1'b1;
                            rsp_data_r  <= 8'h00;
                            rsp_error_r <= 1'b1;
                        end else if (!bus.uart_tx_busy) begin
                            // The op byte goes out in the cycle right after
                            // acceptance, so SEND_OP is skipped here.
                            tx_valid_r <= 1'b1;
                            tx_byte_r  <= {6'b000000, bus.cmd_op};
                            state_r    <= SEND_AH;
                        end else begin
                            state_r <= SEND_OP;
                        end
                    end else begin
                        // Also covers the cycle a response pulses, which keeps
                        // ready low for exactly that cycle.
                        cmd_ready_r <= 1'b1;
                    end
                end
                SEND_OP, SEND_AH, SEND_AL, SEND_DATA: begin
                    if (tx_issue_s) begin
                        tx_valid_r <= 1'b1;
                        tx_byte_r  <= tx_next_byte_s;
                        state_r    <= send_next_s;
                        if (send_next_s == WAIT_RSP) begin
                            wait_cnt_r <= 24'd0;
                        end else begin
                            wait_cnt_r <= wait_cnt_r;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                WAIT_RSP: begin
                    // A reply arriving in the timeout cycle takes priority.
                    if (bus.uart_rx_byte_valid) begin
                        rsp_valid_r <= 1'b1;
                        rsp_data_r  <= bus.uart_rx_byte;
                        rsp_error_r <= status_for(op_r, bus.uart_rx_byte);
                        state_r     <= IDLE;
                    end else if (wait_cnt_r + 24'd1 == TIMEOUT_LIMIT) begin
                        rsp_valid_r <= 1'b1;
                        rsp_data_r  <= 8'h00;
                        rsp_error_r <= 1'b1;
                        wait_cnt_r  <= wait_cnt_r + 24'd1;
                        state_r     <= IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 24'd1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cmd_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready          = cmd_ready_r;
    assign bus.rsp_valid          = rsp_valid_r;
    assign bus.rsp_data           = rsp_data_r;
    assign bus.rsp_error          = rsp_error_r;
    assign bus.uart_tx_byte_valid = tx_valid_r;
    assign bus.uart_tx_byte       = tx_byte_r;

endmodule

// File: tb/tb_c64_debug_host.sv
// tb_c64_debug_host
// Directed bench for c64_debug_host (TIMEOUT_CYCLES=16). Stimulus pushes the
// expected UART bytes and responses into queues; a monitor pops and compares
// whenever the DUT pulses uart_tx_byte_valid or rsp_valid.
module tb_c64_debug_host;
    logic clk = 1'b0;
    logic reset = 1'b0;

    c64_debug_host_if dif();

    c64_debug_host #(.TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       error;
    } rsp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   tx_cnt = 0;
    int   rsp_cnt = 0;
    int   last_tx_cyc = 0;
    int   last_rsp_cyc = 0;
    logic prev_tx = 1'b0;
    logic busy_mode = 1'b0;
    logic [7:0] exp_tx[$];
    rsp_t       exp_rsp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: samples 2 ns after each rising edge.
    initial begin
        rsp_t e;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (dif.uart_tx_byte_valid === 1'b1) begin
                tx_cnt++;
                last_tx_cyc = cyc;
                check("tx_gap", {31'd0, prev_tx}, 32'd0);
                check("tx_while_busy", {31'd0, dif.uart_tx_busy}, 32'd0);
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected actual=0x%0h required=none", dif.uart_tx_byte);
                end else begin
                    check("tx_byte", {24'd0, dif.uart_tx_byte}, {24'd0, exp_tx.pop_front()});
                end
            end
            prev_tx = dif.uart_tx_byte_valid;
            if (dif.rsp_valid === 1'b1) begin
                rsp_cnt++;
                last_rsp_cyc = cyc;
                check("rsp_cmd_ready", {31'd0, dif.cmd_ready}, 32'd0);
                if (exp_rsp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected actual=0x%0h required=none", dif.rsp_data);
                end else begin
                    e = exp_rsp.pop_front();
                    check("rsp_data", {24'd0, dif.rsp_data}, {24'd0, e.data});
                    check("rsp_error", {31'd0, dif.rsp_error}, {31'd0, e.error});
                end
            end
        end
    end

    // Transmitter model: when enabled, busy for 10 cycles after each pulse.
    initial begin
        dif.uart_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_mode && dif.uart_tx_byte_valid === 1'b1) begin
                @(posedge clk);
                #1;
                dif.uart_tx_busy = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                dif.uart_tx_busy = 1'b0;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] data,
                         input bit exp_tx_now, input bit exp_rsp_now);
        int n;
        n = 0;
        while (dif.cmd_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("cmd_ready_wait", {31'd0, dif.cmd_ready}, 32'd1);
        dif.cmd_valid = 1'b1;
        dif.cmd_op    = op;
        dif.cmd_addr  = addr;
        dif.cmd_data  = data;
        @(posedge clk);
        #1;
        dif.cmd_valid = 1'b0;
        dif.cmd_op    = 2'd3;
        dif.cmd_addr  = 16'hFFFF;
        dif.cmd_data  = 8'hFF;
        #2;
        if (exp_tx_now) check("op_latency", {31'd0, dif.uart_tx_byte_valid}, 32'd1);
        if (exp_rsp_now) check("illegal_latency", {31'd0, dif.rsp_valid}, 32'd1);
    endtask

    task automatic wait_tx(input int n);
        int k;
        k = 0;
        while (tx_cnt < n && k < 400) begin
            @(posedge clk);
            #3;
            k++;
        end
        check("tx_count", tx_cnt, n);
    endtask

    task automatic wait_rsp(input int n);
        int k;
        k = 0;
        while (rsp_cnt < n && k < 400) begin
            @(posedge clk);
            #3;
            k++;
        end
        check("rsp_count", rsp_cnt, n);
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk);
        #1;
        dif.uart_rx_byte_valid = 1'b1;
        dif.uart_rx_byte       = b;
        @(posedge clk);
        #1;
        dif.uart_rx_byte_valid = 1'b0;
        dif.uart_rx_byte       = 8'h00;
    endtask

    task automatic check_ready_next;
        @(posedge clk);
        #3;
        check("ready_after_rsp", {31'd0, dif.cmd_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, {31'd0, dif.cmd_ready}, 32'd0);
        check({tag, "_rsp_valid"}, {31'd0, dif.rsp_valid}, 32'd0);
        check({tag, "_rsp_data"}, {24'd0, dif.rsp_data}, 32'd0);
        check({tag, "_rsp_error"}, {31'd0, dif.rsp_error}, 32'd0);
        check({tag, "_tx_valid"}, {31'd0, dif.uart_tx_byte_valid}, 32'd0);
        check({tag, "_tx_byte"}, {24'd0, dif.uart_tx_byte}, 32'd0);
    endtask

    initial begin
        int t;
        int r;
        dif.cmd_valid          = 1'b0;
        dif.cmd_op             = 2'd0;
        dif.cmd_addr           = 16'h0000;
        dif.cmd_data           = 8'h00;
        dif.uart_rx_byte_valid = 1'b0;
        dif.uart_rx_byte       = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b1;
        @(posedge clk);
        #3;
        check("ready_after_reset", {31'd0, dif.cmd_ready}, 32'd1);

        // Read 0xD020, reply 0x0E.
        exp_tx.push_back(8'h01); exp_tx.push_back(8'hD0); exp_tx.push_back(8'h20);
        t = tx_cnt + 3; r = rsp_cnt + 1;
        issue(2'd1, 16'hD020, 8'h99, 1'b1, 1'b0);
        wait_tx(t);
        repeat (2) @(posedge clk);
        exp_rsp.push_back('{data: 8'h0E, error: 1'b0});
        send_rx(8'h0E);
        wait_rsp(r);
        check_ready_next();

        // Write 0x0400 <- 0x41, ack 0x06, then nak 0x15.
        for (int i = 0; i < 2; i++) begin
            exp_tx.push_back(8'h02); exp_tx.push_back(8'h04);
            exp_tx.push_back(8'h00); exp_tx.push_back(8'h41);
            t = tx_cnt + 4; r = rsp_cnt + 1;
            issue(2'd2, 16'h0400, 8'h41, 1'b1, 1'b0);
            wait_tx(t);
            @(posedge clk);
            if (i == 0) begin
                exp_rsp.push_back('{data: 8'h06, error: 1'b0});
                send_rx(8'h06);
            end else begin
                exp_rsp.push_back('{data: 8'h15, error: 1'b1});
                send_rx(8'h15);
            end
            wait_rsp(r);
            check_ready_next();
        end

        // Read with no reply: timeout 16 cycles after entering WAIT_RSP.
        exp_tx.push_back(8'h01); exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
        exp_rsp.push_back('{data: 8'h00, error: 1'b1});
        t = tx_cnt + 3; r = rsp_cnt + 1;
        issue(2'd1, 16'h1234, 8'h00, 1'b1, 1'b0);
        wait_tx(t);
        wait_rsp(r);
        check("timeout_latency", last_rsp_cyc - last_tx_cyc, 32'd16);
        check_ready_next();

        // Read with the reply landing in the 16th wait cycle: reply wins.
        exp_tx.push_back(8'h01); exp_tx.push_back(8'hAB); exp_tx.push_back(8'hCD);
        exp_rsp.push_back('{data: 8'h77, error: 1'b0});
        t = tx_cnt + 3; r = rsp_cnt + 1;
        issue(2'd1, 16'hABCD, 8'h00, 1'b1, 1'b0);
        wait_tx(t);
        repeat (15) @(posedge clk);
        #1;
        dif.uart_rx_byte_valid = 1'b1;
        dif.uart_rx_byte       = 8'h77;
        @(posedge clk);
        #1;
        dif.uart_rx_byte_valid = 1'b0;
        wait_rsp(r);
        check("rx_at_timeout_latency", last_rsp_cyc - last_tx_cyc, 32'd16);
        check_ready_next();

        // ps2 0x1C with a slow transmitter.
        busy_mode = 1'b1;
        exp_tx.push_back(8'h03); exp_tx.push_back(8'h1C); exp_tx.push_back(8'h00);
        exp_rsp.push_back('{data: 8'h00, error: 1'b0});
        t = tx_cnt + 3; r = rsp_cnt + 1;
        issue(2'd3, 16'h5555, 8'h1C, 1'b1, 1'b0);
        wait_tx(t);
        wait_rsp(r);
        check("ps2_rsp_latency", last_rsp_cyc - last_tx_cyc, 32'd1);
        busy_mode = 1'b0;
        repeat (15) @(posedge clk);
        #1;

        // Illegal op: error response next cycle, no bytes.
        exp_rsp.push_back('{data: 8'h00, error: 1'b1});
        t = tx_cnt; r = rsp_cnt + 1;
        issue(2'd0, 16'h1111, 8'h22, 1'b0, 1'b1);
        wait_rsp(r);
        check_ready_next();
        check("illegal_no_tx", tx_cnt, t);

        // Reset during WAIT_RSP, then a stray reply after release.
        exp_tx.push_back(8'h01); exp_tx.push_back(8'hC0); exp_tx.push_back(8'hDE);
        t = tx_cnt + 3; r = rsp_cnt;
        issue(2'd1, 16'hC0DE, 8'h00, 1'b1, 1'b0);
        wait_tx(t);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        check_reset_outputs("mid_reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        send_rx(8'h55);
        repeat (20) @(posedge clk);
        #3;
        check("reset_no_rsp", rsp_cnt, r);
        check("reset_no_tx", tx_cnt, t);
        check("ready_after_mid_reset", {31'd0, dif.cmd_ready}, 32'd1);

        // Next read completes normally.
        exp_tx.push_back(8'h01); exp_tx.push_back(8'hD0); exp_tx.push_back(8'h21);
        t = tx_cnt + 3; r = rsp_cnt + 1;
        issue(2'd1, 16'hD021, 8'h00, 1'b1, 1'b0);
        wait_tx(t);
        @(posedge clk);
        exp_rsp.push_back('{data: 8'h03, error: 1'b0});
        send_rx(8'h03);
        wait_rsp(r);
        check_ready_next();

        check("tx_queue_left", exp_tx.size(), 32'd0);
        check("rsp_queue_left", exp_rsp.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/c64_debug_host.md
C64_DEBUG_HOST -- requirements
Module: c64_debug_host

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1000000, response wait limit in clk cycles, range 1 to 2^24-1.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_op  in  2  command: 1=read, 2=write, 3=ps2, 0=illegal.
REQ-007 cmd_addr  in  16  target address.
REQ-008 cmd_data  in  8  write data, or ps2 byte.
REQ-009 rsp_valid  out  1  one-cycle pulse marking command completion.
REQ-010 rsp_data  out  8  read data or received ack byte; held until the next rsp_valid.
REQ-011 rsp_error  out  1  completion status; qualified by rsp_valid, held with rsp_data.
REQ-012 uart_tx_byte_valid  out  1  one-cycle pulse presenting uart_tx_byte to the transmitter.
REQ-013 uart_tx_byte  out  8  byte to send; held stable from its pulse until the next pulse.
REQ-014 uart_tx_busy  in  1  transmitter busy; no pulse is issued while high.
REQ-015 uart_rx_byte_valid  in  1  one-cycle strobe for a received byte.
REQ-016 uart_rx_byte  in  8  received byte.

Function
REQ-017 States: IDLE, SEND_OP, SEND_AH, SEND_AL, SEND_DATA, WAIT_RSP.
REQ-018 On acceptance, latch cmd_op, cmd_addr and cmd_data; later changes on the cmd_* inputs have no effect.
REQ-019 Accepted op 1, 2 or 3: go to SEND_OP.
REQ-020 Accepted op 0: stay in IDLE, pulse rsp_valid on the next cycle with rsp_error=1 and rsp_data=0x00, and send no bytes.
REQ-021 Send state byte issue: pulse uart_tx_byte_valid when uart_tx_busy=0 and the previous cycle had no pulse (one-cycle gap), then advance to the next state.
REQ-022 Byte sequence, read: 0x01, addr[15:8], addr[7:0], then WAIT_RSP.
REQ-023 Byte sequence, write: 0x02, addr[15:8], addr[7:0], data, then WAIT_RSP.
REQ-024 Byte sequence, ps2: 0x03, data, 0x00, then IDLE; pulse rsp_valid in the cycle after the last byte pulse, with rsp_error=0 and rsp_data=0x00.
REQ-025 Latency: command accepted in cycle N with uart_tx_busy low -> op byte pulse in cycle N+1.
REQ-026 WAIT_RSP, first uart_rx_byte_valid: pulse rsp_valid in the next cycle, with rsp_data=uart_rx_byte, then go to IDLE.
REQ-027 WAIT_RSP rsp_error: 0 for read; for write, 0 if the byte is 0x06, else 1.
REQ-028 WAIT_RSP timeout counter (24 bit): cleared on entry, increments each cycle without an rx strobe.
REQ-029 Timeout: when the counter reaches TIMEOUT_CYCLES, pulse rsp_valid with rsp_error=1 and rsp_data=0x00, then go to IDLE.
REQ-030 An rx strobe in the same cycle as timeout wins: normal response, no error.
REQ-031 rx strobes outside WAIT_RSP are ignored: no effect on state or outputs.
REQ-032 While in IDLE, the counter does not count.
REQ-033 uart_tx_busy held high stalls the send states indefinitely; there is no timeout in send states.
REQ-034 cmd_ready=0 in every non-IDLE state and in the cycle rsp_valid pulses, so there is at most one outstanding command.

Reset
REQ-035 reset low forces immediately, regardless of clk, and holds while low: state=IDLE, counter=0, gap flag=0, latched command=0.
REQ-036 While reset is low, outputs are: cmd_ready=0, rsp_valid=0, rsp_data=0x00, rsp_error=0, uart_tx_byte_valid=0, uart_tx_byte=0x00.
REQ-037 cmd_ready=1 from the first clk edge after reset goes high.
REQ-038 Reset mid-command abandons the command without a response; bytes already sent are not recalled.

Verification
REQ-039 Read op=1, addr=0xD020, busy low; rx 0x0E after the last byte -> tx 0x01,0xD0,0x20 with >=1 idle cycle between pulses; rsp_valid once, rsp_data=0x0E, rsp_error=0.
REQ-040 Write op=2, addr=0x0400, data=0x41; rx 0x06 -> tx 0x02,0x04,0x00,0x41; rsp_error=0. Repeat with rx 0x15 -> rsp_data=0x15, rsp_error=1.
REQ-041 Read with TIMEOUT_CYCLES=16 and no rx -> rsp_valid exactly 16 cycles after WAIT_RSP entry, rsp_error=1, rsp_data=0x00, cmd_ready=1 the next cycle; also rx arriving on cycle 16 -> normal response.
REQ-042 ps2 op=3, data=0x1C, with uart_tx_busy high for 10 cycles after each pulse -> tx 0x03,0x1C,0x00, no pulse while busy, rsp_valid with error 0; also op 0 -> error response, no tx.
REQ-043 Reset low during WAIT_RSP, then rx 0x55 after release -> no rsp_valid; outputs at reset values; the next read completes normally.
